fifo_access_ctrl: RTL and testbench

//  Sequences the shared 32-bit, 5-entry user-area FIFO between two producers and one consumer.
//  - Round-robin arbitrates producer writes.
//  - Turns the FIFO's registered read port into a valid/ready stream.
//  - Drives the FIFO's sync active-high reset for flush.
//  - Never issues a write/read pair the FIFO cannot count correctly.

---
 rtl/fifo_access_ctrl_pkg.sv | 15 +
 rtl/fifo_access_ctrl_rr_arb2.sv | 30 +++
 rtl/fifo_access_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_access_ctrl_pkg.sv
// Shared definitions for the FIFO access controller: default widths and the
// read-sequencer state encoding.
package fifo_access_ctrl_pkg;

  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;
  localparam int FIFO_DEPTH = 5;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational and gated by adv_i;
// the last-grant register only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] grant_o
);

  // last_q = 1 means requester 1 won most recently, so requester 0 has priority
  logic last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    if (adv_i) begin
      if (req_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
      else                grant_o = req_i;
    end
    last_d = last_q;
    if (grant_o[0])      last_d = 1'b0;
    else if (grant_o[1]) last_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Sequences a shared 5-entry FIFO: round-robin producer writes, registered read
// port turned into a valid/ready stream, flush handling and grant counters.
module fifo_access_ctrl
  import fifo_access_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             p0_valid,
  input  logic [DW-1:0]    p0_data,
  output logic             p0_ready,
  input  logic             p1_valid,
  input  logic [DW-1:0]    p1_data,
  output logic             p1_ready,
  output logic             fifo_reset,
  output logic             fifo_wr_en,
  output logic [DW-1:0]    fifo_wr_data,
  output logic             fifo_rd_en,
  input  logic [DW-1:0]    fifo_rd_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] p0_grants,
  output logic [CNT_W-1:0] p1_grants
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rd_state_e        state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             fifo_rst_q;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]       grant;
  logic             wr_allow, rd_slot, rd_want;

  // A full FIFO may only drain and an empty one may only fill, so the pair
  // rule falls out of gating writes on ~full and reads on ~empty.
  assign wr_allow = ~fifo_full & ~flush & ~fifo_rst_q;
  assign rd_slot  = (state_q == RD_IDLE) |
                    ((state_q == RD_HOLD) & m_valid_q & m_ready);
  assign rd_want  = rd_slot & ~fifo_empty & ~flush & ~fifo_rst_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req_i   ({p1_valid, p0_valid}),
    .adv_i   (wr_allow),
    .grant_o (grant)
  );

  assign p0_ready     = grant[0];
  assign p1_ready     = grant[1];
  assign fifo_wr_en   = |grant;
  assign fifo_wr_data = grant[1] ? p1_data : p0_data;
  assign fifo_rd_en   = rd_want;
  assign fifo_reset   = fifo_rst_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign p0_grants    = cnt0_q;
  assign p1_grants    = cnt1_q;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    case (state_q)
      RD_IDLE: if (rd_want) state_d = RD_FETCH;
      RD_FETCH: begin
        m_data_d  = fifo_rd_data;
        m_valid_d = 1'b1;
        state_d   = RD_HOLD;
      end
      RD_HOLD: if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
        state_d   = rd_want ? RD_FETCH : RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    if (flush) begin
      state_d   = RD_IDLE;
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant[0] && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
    if (grant[1] && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      fifo_rst_q <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      fifo_rst_q <= flush;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural FIFO, cycle-level reference model with
// an expected-word queue, directed vector table and randomized traffic.
module tb_fifo_access_ctrl;

  localparam int DW    = 32;
  localparam int CNT_W = 16;
  localparam int SCW   = 3;
  localparam int DEPTH = 5;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush = 1'b0, p0_valid = 1'b0, p1_valid = 1'b0, m_ready = 1'b0;
  logic [DW-1:0]    p0_data = '0, p1_data = '0;
  logic             p0_ready, p1_ready, fifo_reset, fifo_wr_en, fifo_rd_en, m_valid;
  logic [DW-1:0]    fifo_wr_data, m_data;
  logic [DW-1:0]    fifo_rd_data = '0;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] p0_grants, p1_grants;

  logic             s_p0_ready, s_p1_ready, s_fifo_reset, s_fifo_wr_en, s_fifo_rd_en, s_m_valid;
  logic [DW-1:0]    s_fifo_wr_data, s_m_data;
  logic [SCW-1:0]   s_p0_grants, s_p1_grants;

  fifo_access_ctrl #(.DW(DW), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .fifo_reset(fifo_reset), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .p0_grants(p0_grants), .p1_grants(p1_grants)
  );

  // Narrow-counter twin on the same inputs, used to exercise saturation.
  fifo_access_ctrl #(.DW(DW), .CNT_W(SCW)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(s_p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(s_p1_ready),
    .fifo_reset(s_fifo_reset), .fifo_wr_en(s_fifo_wr_en), .fifo_wr_data(s_fifo_wr_data),
    .fifo_rd_en(s_fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .m_valid(s_m_valid), .m_data(s_m_data), .m_ready(m_ready),
    .p0_grants(s_p0_grants), .p1_grants(s_p1_grants)
  );

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  logic          smp_wr = 1'b0, smp_rd = 1'b0, smp_rst = 1'b1;
  logic [DW-1:0] smp_wdata = '0;

  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  always @(negedge clk) begin
    smp_wr    = fifo_wr_en;
    smp_rd    = fifo_rd_en;
    smp_rst   = fifo_reset;
    smp_wdata = fifo_wr_data;
  end

  always @(posedge clk) begin
    if (smp_rst) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (smp_rd && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (smp_wr && fq.size() < DEPTH) fq.push_back(smp_wdata);
      fcnt <= fq.size();
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic          m_last = 1'b1, m_rst = 1'b1;
  int            m_cnt0 = 0, m_cnt1 = 0;
  logic          prev_hold = 1'b0, prev_flush = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_last = 1'b1; m_rst = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
      prev_hold = 1'b0; prev_flush = 1'b0;
    end else begin
      logic g0, g1, elig, bad_rd;
      g0 = 1'b0; g1 = 1'b0;
      chk("mon_fifo_reset", fifo_reset, m_rst);
      elig = !fifo_full && !m_rst && !flush;
      if (elig) begin
        g0 = p0_valid && (!p1_valid || m_last);
        g1 = p1_valid && (!p0_valid || !m_last);
      end
      chk("mon_p0_ready", p0_ready, g0);
      chk("mon_p1_ready", p1_ready, g1);
      chk("mon_wr_en", fifo_wr_en, g0 | g1);
      if (g0 || g1) chk("mon_wr_data", fifo_wr_data, g0 ? p0_data : p1_data);
      chk("mon_p0_grants", p0_grants, m_cnt0);
      chk("mon_p1_grants", p1_grants, m_cnt1);
      chk("mon_p0_grants_sat", s_p0_grants, (m_cnt0 > 7) ? 7 : m_cnt0);
      chk("mon_p1_grants_sat", s_p1_grants, (m_cnt1 > 7) ? 7 : m_cnt1);
      bad_rd = fifo_rd_en && (fifo_empty || m_rst || flush || (fifo_wr_en && fifo_full));
      chk("mon_rd_en_legal", bad_rd, 1'b0);
      if (prev_flush) chk("mon_valid_after_flush", m_valid, 1'b0);
      if (prev_hold) begin
        chk("mon_hold_valid", m_valid, 1'b1);
        chk("mon_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("mon_unexpected_word", 1'b1, 1'b0);
        else chk("mon_m_data", m_data, exp_q.pop_front());
      end
      if (g0) begin
        exp_q.push_back(p0_data);
        if (m_cnt0 < 65535) m_cnt0++;
        m_last = 1'b0;
      end
      if (g1) begin
        exp_q.push_back(p1_data);
        if (m_cnt1 < 65535) m_cnt1++;
        m_last = 1'b1;
      end
      if (flush) exp_q.delete();
      m_rst      = flush;
      prev_hold  = m_valid && !m_ready && !flush;
      prev_data  = m_data;
      prev_flush = flush;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fl, input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic mr);
    flush = fl; p0_valid = v0; p0_data = d0; p1_valid = v1; p1_data = d1; m_ready = mr;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(0, 0, '0, 0, '0, 0);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_p0_grants", p0_grants, '0);
    chk("rst_p1_grants", p1_grants, '0);
    chk("rst_fifo_reset", fifo_reset, 1'b1);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_fifo_reset_after_release", fifo_reset, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int k;
    drive(0, 0, '0, 0, '0, 1);
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !m_valid && fifo_empty) break;
    end
    chk("drain_complete", k < budget, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          fl;
    logic          p0v;
    logic [DW-1:0] p0d;
    logic          p1v;
    logic [DW-1:0] p1d;
    logic          mr;
    logic [5:0]    e;   // {p0_ready, p1_ready, wr_en, rd_en, m_valid, fifo_reset}
    logic [DW-1:0] md;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic p0v, input logic [DW-1:0] p0d,
                     input logic p1v, input logic [DW-1:0] p1d, input logic mr,
                     input logic [5:0] e, input logic [DW-1:0] md);
    vec_t v;
    v.rst = rst; v.fl = fl; v.p0v = p0v; v.p0d = p0d; v.p1v = p1v; v.p1d = p1d;
    v.mr = mr; v.e = e; v.md = md;
    vecs.push_back(v);
  endtask

  initial begin
    // In-order delivery at one word per two cycles
    add(1, 0, 1, 32'hA0, 0, '0, 1, 6'b101000, '0);
    add(0, 0, 1, 32'hA1, 0, '0, 1, 6'b101100, '0);
    add(0, 0, 1, 32'hA2, 0, '0, 1, 6'b101000, '0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000110, 32'hA0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000000, '0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000110, 32'hA1);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000000, '0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000010, 32'hA2);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000000, '0);
    // Write into an empty FIFO: read deferred one cycle
    add(1, 0, 0, '0, 1, 32'hD0, 0, 6'b011000, '0);
    add(0, 0, 0, '0, 0, '0, 0, 6'b000100, '0);
    add(0, 0, 0, '0, 0, '0, 0, 6'b000000, '0);
    add(0, 0, 0, '0, 0, '0, 0, 6'b000010, 32'hD0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000010, 32'hD0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000000, '0);
    // Both producers, consumer stalled: alternate until full
    add(1, 0, 1, 32'hB0, 1, 32'hC0, 0, 6'b101000, '0);
    add(0, 0, 1, 32'hB1, 1, 32'hC1, 0, 6'b011100, '0);
    add(0, 0, 1, 32'hB2, 1, 32'hC2, 0, 6'b101000, '0);
    add(0, 0, 1, 32'hB3, 1, 32'hC3, 0, 6'b011010, 32'hB0);
    add(0, 0, 1, 32'hB4, 1, 32'hC4, 0, 6'b101010, 32'hB0);
    add(0, 0, 1, 32'hB5, 1, 32'hC5, 0, 6'b011010, 32'hB0);
    add(0, 0, 1, 32'hB6, 1, 32'hC6, 0, 6'b000010, 32'hB0);
    // Long consumer stall in HOLD
    for (int i = 0; i < 10; i++) add(0, 0, 0, '0, 0, '0, 0, 6'b000010, 32'hB0);
    // Full FIFO: read first, write lands next cycle
    add(0, 0, 1, 32'hE0, 0, '0, 1, 6'b000110, 32'hB0);
    add(0, 0, 1, 32'hE1, 0, '0, 1, 6'b101000, '0);
    add(0, 0, 0, '0, 0, '0, 1, 6'b000110, 32'hC1);
  end

  // ---------------- test sequence ----------------
  initial begin
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else begin
        @(posedge clk); #1;
      end
      drive(vecs[i].fl, vecs[i].p0v, vecs[i].p0d, vecs[i].p1v, vecs[i].p1d, vecs[i].mr);
      @(negedge clk);
      chk($sformatf("row%0d_p0_ready", i), p0_ready, vecs[i].e[5]);
      chk($sformatf("row%0d_p1_ready", i), p1_ready, vecs[i].e[4]);
      chk($sformatf("row%0d_wr_en", i), fifo_wr_en, vecs[i].e[3]);
      chk($sformatf("row%0d_rd_en", i), fifo_rd_en, vecs[i].e[2]);
      chk($sformatf("row%0d_m_valid", i), m_valid, vecs[i].e[1]);
      chk($sformatf("row%0d_fifo_reset", i), fifo_reset, vecs[i].e[0]);
      if (vecs[i].e[1]) chk($sformatf("row%0d_m_data", i), m_data, vecs[i].md);
    end
    drain(40);

    // Flush with words queued, then asynchronous reset in FETCH
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hF0 + i, 0, '0, 0);
      @(negedge clk);
      chk("fl_fill_ready", p0_ready, 1'b1);
      @(posedge clk); #1;
    end
    drive(1, 1, 32'hF9, 0, '0, 1);
    @(negedge clk);
    chk("fl_flush_cycle_ready", p0_ready, 1'b0);
    chk("fl_flush_cycle_rd_en", fifo_rd_en, 1'b0);
    chk("fl_flush_cycle_m_data", m_data, 32'hF0);
    @(posedge clk); #1;
    drive(0, 1, 32'hF3, 0, '0, 1);
    @(negedge clk);
    chk("fl_fifo_reset", fifo_reset, 1'b1);
    chk("fl_reset_cycle_ready", p0_ready, 1'b0);
    chk("fl_reset_cycle_rd_en", fifo_rd_en, 1'b0);
    chk("fl_m_valid_cleared", m_valid, 1'b0);
    @(posedge clk); #1;
    drive(0, 1, 32'hF4, 0, '0, 1);
    @(negedge clk);
    chk("fl_fifo_empty", fifo_empty, 1'b1);
    chk("fl_fifo_reset_done", fifo_reset, 1'b0);
    chk("fl_post_ready", p0_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, '0, 0, '0, 1);
    @(negedge clk);
    chk("fl_post_rd_en", fifo_rd_en, 1'b1);
    @(posedge clk); #1;
    chk("fl_counts_kept", p0_grants, 16'd4);
    drive(0, 1, 32'hF5, 0, '0, 1);
    reset_n = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 1'b0);
    chk("async_m_data", m_data, '0);
    chk("async_p0_grants", p0_grants, '0);
    chk("async_wr_en", fifo_wr_en, 1'b0);
    chk("async_rd_en", fifo_rd_en, 1'b0);
    chk("async_fifo_reset", fifo_reset, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) do_reset();
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0, $urandom,
            $urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
